alu_arbiter4: RTL and testbench

ALU_ARBITER4 -- requirements
Module: alu_arbiter4

---
 rtl/alu_arbiter4.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter4.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter4.sv
// Four-way round-robin arbiter with a hold-time limit, driving a shared mux4 of operands.
// Grant, select and valid are registered; the muxed data output is combinational.
module alu_arbiter4 #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       select,
    output logic             valid,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    typedef enum logic [2:0] {
        ACT_STAY    = 3'd0,
        ACT_NEW     = 3'd1,
        ACT_HOLD    = 3'd2,
        ACT_RENEW   = 3'd3,
        ACT_RELEASE = 3'd4
    } act_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state, w_state_nxt;
    act_t       w_act;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_hcnt, w_hcnt_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic [1:0] r_select, w_select_nxt;
    logic       r_valid, w_valid_nxt;
    logic       w_win_found;
    logic [1:0] w_win_idx;
    logic       w_own_req;
    logic       w_others;
    logic       w_timeout;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Round-robin scan: descending offsets so the smallest offset from ptr is kept last.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_win_found = 1'b1;
                w_win_idx   = r_ptr + 2'(k);
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    assign w_own_req = req[r_select];
    assign w_others  = |(req & ~r_gnt);
    assign w_timeout = (r_hcnt == HOLD_LAST);

    // Decide what this edge does to the grant; the owner is always last in scan order on timeout.
    always_comb begin
        w_act = ACT_STAY;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) w_act = ACT_NEW;
                else             w_act = ACT_STAY;
            end
            ST_GRANT: begin
                if (!w_own_req) begin
                    if (w_win_found) w_act = ACT_NEW;
                    else             w_act = ACT_RELEASE;
                end else if (!w_timeout) begin
                    w_act = ACT_HOLD;
                end else if (w_others) begin
                    w_act = ACT_NEW;
                end else begin
                    w_act = ACT_RENEW;
                end
            end
            default: w_act = ACT_RELEASE;
        endcase
    end

    // Next-state and next-output values for the chosen action.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_hcnt_nxt   = r_hcnt;
        w_gnt_nxt    = r_gnt;
        w_select_nxt = r_select;
        w_valid_nxt  = r_valid;
        case (w_act)
            ACT_NEW: begin
                w_state_nxt  = ST_GRANT;
                w_ptr_nxt    = w_win_idx + 2'd1;
                w_hcnt_nxt   = 8'd0;
                w_gnt_nxt    = onehot4(w_win_idx);
                w_select_nxt = w_win_idx;
                w_valid_nxt  = 1'b1;
            end
            ACT_HOLD:  w_hcnt_nxt = r_hcnt + 8'd1;
            ACT_RENEW: w_hcnt_nxt = 8'd0;
            ACT_STAY:  w_hcnt_nxt = r_hcnt;
            default: begin
                w_state_nxt  = ST_IDLE;
                w_hcnt_nxt   = 8'd0;
                w_gnt_nxt    = 4'b0000;
                w_select_nxt = 2'd0;
                w_valid_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd0;
            r_hcnt   <= 8'd0;
            r_gnt    <= 4'b0000;
            r_select <= 2'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_select <= w_select_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    // Shared operand mux, forced to zero when nothing is granted.
    always_comb begin
        out = '0;
        if (r_valid) begin
            case (r_select)
                2'd0:    out = a;
                2'd1:    out = b;
                2'd2:    out = c;
                2'd3:    out = d;
                default: out = '0;
            endcase
        end else begin
            out = '0;
        end
    end

    assign gnt    = r_gnt;
    assign select = r_select;
    assign valid  = r_valid;

endmodule

// File: tb/tb_alu_arbiter4.sv
// Bench for alu_arbiter4: directed scenarios with literal expectations plus a
// cycle-by-cycle comparison against a behavioural round-robin model.
module tb_alu_arbiter4;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [3:0]       req   = 4'b0000;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic [WIDTH-1:0] c     = '0;
    logic [WIDTH-1:0] d     = '0;
    logic [3:0]       gnt;
    logic [1:0]       select;
    logic             valid;
    logic [WIDTH-1:0] out;

    int n_checks = 0;
    int n_errors = 0;
    int wait_cnt [4] = '{0, 0, 0, 0};

    // owner = -1 when idle; run = consecutive cycles the owner has held the grant.
    typedef struct {
        int owner;
        int run;
        int ptr;
    } mstate_t;

    mstate_t m = '{owner: -1, run: 0, ptr: 0};

    logic [3:0] s2_req [7] = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] s2_gnt [7] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] s2_out [7] = '{4'b1001, 4'b1001, 4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0000};

    always #5 clk = ~clk;

    alu_arbiter4 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .gnt    (gnt),
        .select (select),
        .valid  (valid),
        .out    (out)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic mstate_t step(input mstate_t s, input logic [3:0] r);
        mstate_t n = s;
        int win = -1;
        for (int k = 0; k < 4; k++) begin
            if (win < 0 && r[2'((s.ptr + k) % 4)]) win = (s.ptr + k) % 4;
        end
        if (s.owner < 0 || !r[2'(s.owner)]) begin
            if (win >= 0) n = '{owner: win, run: 1, ptr: (win + 1) % 4};
            else          n = '{owner: -1, run: 0, ptr: s.ptr};
        end else if (s.run < MAX_HOLD) begin
            n.run = s.run + 1;
        end else if ((r & ~(4'b0001 << s.owner)) != 4'b0000) begin
            n = '{owner: win, run: 1, ptr: (win + 1) % 4};
        end else begin
            n.run = 1;
        end
        return n;
    endfunction

    function automatic logic [3:0] m_gnt(input mstate_t s);
        return (s.owner < 0) ? 4'b0000 : (4'b0001 << s.owner);
    endfunction

    function automatic logic [WIDTH-1:0] m_out(input mstate_t s, input logic [WIDTH-1:0] va,
                                               input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vc,
                                               input logic [WIDTH-1:0] vd);
        case (s.owner)
            0:       return va;
            1:       return vb;
            2:       return vc;
            3:       return vd;
            default: return '0;
        endcase
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{owner: -1, run: 0, ptr: 0};
        else        m <= step(m, req);
    end

    // Per-cycle comparison against the model, plus structural and fairness properties.
    always @(negedge clk) begin
        chk("gnt", 32'(gnt), 32'(m_gnt(m)));
        chk("select", 32'(select), (m.owner < 0) ? 32'd0 : 32'(m.owner));
        chk("valid", 32'(valid), (m.owner < 0) ? 32'd0 : 32'd1);
        chk("out", 32'(out), 32'(m_out(m, a, b, c, d)));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("valid_vs_gnt", 32'(valid), 32'(|gnt));
        for (int i = 0; i < 4; i++) begin
            if (!rst_n || gnt[i] || !req[i]) begin
                wait_cnt[i] <= 0;
            end else begin
                wait_cnt[i] <= wait_cnt[i] + 1;
                chk("fair_wait", 32'(wait_cnt[i] + 1 <= 3 * MAX_HOLD), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic [WIDTH-1:0] eo);
        chk({name, "_gnt"}, 32'(gnt), 32'(eg));
        chk({name, "_select"}, 32'(select), 32'(es));
        chk({name, "_valid"}, 32'(valid), 32'(ev));
        chk({name, "_out"}, 32'(out), 32'(eo));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        pin("reset", 4'b0000, 2'd0, 1'b0, 4'b0000);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single requester
        a   = 4'b1010;
        req = 4'b0001;
        tick();
        pin("single", 4'b0001, 2'd0, 1'b1, 4'b1010);
        req = 4'b0000;
        tick();
        pin("single_drop", 4'b0000, 2'd0, 1'b0, 4'b0000);

        // Round robin 1,2,3 with no idle gap
        b = 4'b1001;
        c = 4'b0101;
        d = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            req = s2_req[k];
            tick();
            chk("rr_gnt", 32'(gnt), 32'(s2_gnt[k]));
            chk("rr_out", 32'(out), 32'(s2_out[k]));
        end

        // Timeout alternation between requesters 0 and 3
        req = 4'b1001;
        for (int k = 0; k < 24; k++) begin
            tick();
            chk("timeout_gnt", 32'(gnt), (((k / 8) % 2) == 0) ? 32'(4'b0001) : 32'(4'b1000));
        end
        req = 4'b0000;
        tick();

        // Solo requester never loses the grant
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            tick();
            pin("solo", 4'b0100, 2'd2, 1'b1, 4'b0101);
        end
        req = 4'b0000;
        tick();

        // Asynchronous reset mid-grant
        req = 4'b0010;
        tick();
        pin("pre_rst", 4'b0010, 2'd1, 1'b1, 4'b1001);
        #1 rst_n = 1'b0;
        #1;
        pin("async_rst", 4'b0000, 2'd0, 1'b0, 4'b0000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        pin("post_rst", 4'b0010, 2'd1, 1'b1, 4'b1001);
        req = 4'b0000;
        tick();

        // Pointer restarts at requester 0 after reset
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        req = 4'b1010;
        tick();
        pin("ptr_rst", 4'b0010, 2'd1, 1'b1, 4'b1001);
        req = 4'b0000;
        tick();

        // Random traffic checked by the model
        for (int k = 0; k < 200; k++) begin
            if ((k % 3) == 0) req = 4'($urandom);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            c = WIDTH'($urandom);
            d = WIDTH'($urandom);
            tick();
        end

        // Everyone requesting: fairness bound exercised
        req = 4'b1111;
        for (int k = 0; k < 80; k++) tick();
        req = 4'b0000;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
